// File: rtl/oci_trace_capture.sv
// rtl/oci_trace_capture.sv - circular debug-trace capture buffer with post-trigger freeze and drain port
module oci_trace_capture #(
    parameter int DATA_W    = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int WRAP      = 1,
    parameter int POST_TRIG = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       dct_buffer,
    input  logic [CNT_W-1:0]        dct_count,
    input  logic                    dct_valid,
    input  logic                    test_ending,
    input  logic                    test_has_ended,
    output logic [CNT_W+DATA_W-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [ADDR_W:0]         fill_level,
    output logic                    overflow,
    output logic [1:0]              cap_state,
    output logic                    done
);
    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_POST    = 2'd1;
    localparam logic [1:0] ST_FROZEN  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   POST_INIT = (ADDR_W+1)'(POST_TRIG);
    localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [CNT_W+DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [ADDR_W:0]   post_q, post_d;
    logic              ovf_q, ovf_d;
    logic              full, push_req, push_acc, pop;

    assign rd_valid   = (state_q == ST_FROZEN) && (fill_q != '0);
    assign rd_data    = mem[rd_ptr_q];
    assign fill_level = fill_q;
    assign overflow   = ovf_q;
    assign cap_state  = state_q;
    assign done       = (state_q == ST_DONE);

    always_comb begin
        full     = (fill_q == FULL_LVL);
        push_req = dct_valid && (dct_count != '0) &&
                   ((state_q == ST_CAPTURE) || (state_q == ST_POST));
        push_acc = push_req && (!full || (WRAP != 0));
        pop      = rd_valid && rd_ready;

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        post_d   = post_q;
        ovf_d    = ovf_q | (push_req && full);

        // A wrapping push into a full buffer evicts the oldest entry, so the level holds.
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (full) rd_ptr_d = rd_ptr_q + PTR_ONE;
            else      fill_d   = fill_q + LVL_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            fill_d   = fill_q - LVL_ONE;
        end

        case (state_q)
            ST_CAPTURE: begin
                if (test_has_ended)   state_d = ST_FROZEN;
                else if (test_ending) state_d = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
            end
            ST_POST: begin
                if (test_has_ended) begin
                    state_d = ST_FROZEN;
                end else if (push_acc) begin
                    post_d = post_q - LVL_ONE;
                    if (post_q == LVL_ONE) state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (fill_q == '0) state_d = ST_DONE;
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_CAPTURE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            post_q   <= POST_INIT;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            post_q   <= post_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) mem[wr_ptr_q] <= {dct_count, dct_buffer};
    end
endmodule
